// File: rtl/alu_pkg.sv
// Shared encodings for the ALU / multiply-divide unit: op codes, MD select,
// controller states and shifter op selects.
package alu_pkg;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  typedef enum logic [1:0] {
    MD_ALU = 2'b00,
    MD_MUL = 2'b01,
    MD_DIV = 2'b10,
    MD_RSV = 2'b11
  } md_t;

  typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shift_op_t;

  // ALUFun[5:4] group select
  localparam logic [1:0] GRP_ARITH = 2'b00;
  localparam logic [1:0] GRP_LOGIC = 2'b01;
  localparam logic [1:0] GRP_SHIFT = 2'b10;
  localparam logic [1:0] GRP_CMP   = 2'b11;

  localparam logic [5:0] FUN_ADD = 6'b000000;
  localparam logic [5:0] FUN_SUB = 6'b000001;
  localparam logic [5:0] FUN_AND = 6'b011000;
  localparam logic [5:0] FUN_OR  = 6'b011110;
  localparam logic [5:0] FUN_XOR = 6'b010110;
  localparam logic [5:0] FUN_NOR = 6'b010001;
  localparam logic [5:0] FUN_SLL = 6'b100000;
  localparam logic [5:0] FUN_SRL = 6'b100001;
  localparam logic [5:0] FUN_SRA = 6'b100011;
  localparam logic [5:0] FUN_EQ  = 6'b110011;
  localparam logic [5:0] FUN_NE  = 6'b110001;
  localparam logic [5:0] FUN_LT  = 6'b110101;
  localparam logic [5:0] FUN_LEZ = 6'b111101;
  localparam logic [5:0] FUN_LTZ = 6'b111011;
  localparam logic [5:0] FUN_GTZ = 6'b111111;

endpackage

// File: rtl/alu_shifter.sv
// Log-stage barrel shifter (SLL/SRL/SRA). Left shifts reuse the right-shift
// stages by bit-reversing the data on the way in and out.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   shamt,
  input  shift_op_t        op,
  output logic [WIDTH-1:0] result_c
);

  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] stage;
  logic [WIDTH-1:0] ones;
  logic             fill;

  always_comb begin
    src      = '0;
    stage    = '0;
    result_c = '0;
    ones     = '1;
    fill     = (op == SH_SRA) && data[WIDTH-1];
    for (int i = 0; i < int'(WIDTH); i++) begin
      src[i] = (op == SH_SLL) ? data[WIDTH-1-i] : data[i];
    end
    stage = src;
    for (int s = 0; s < int'(SHW); s++) begin
      if (shamt[s]) begin
        stage = (stage >> (1 << s)) | (fill ? ~(ones >> (1 << s)) : '0);
      end
    end
    for (int i = 0; i < int'(WIDTH); i++) begin
      result_c[i] = (op == SH_SLL) ? stage[WIDTH-1-i] : stage[i];
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Single-cycle ALU plus iterative shift-add multiplier and restoring divider
// behind a valid/ready handshake with registered results.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       ALUFun,
  input  logic             Sign,
  input  logic [1:0]       MD,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] Zhi,
  output logic             V,
  output logic             dz
);

  localparam int unsigned MSB = WIDTH - 1;

  state_t             state, state_nxt;
  logic [SHW-1:0]     cnt, cnt_nxt;
  logic [WIDTH:0]     hi, hi_nxt;
  logic [WIDTH-1:0]   lo, lo_nxt, opnd, opnd_nxt;
  logic               is_div, is_div_nxt, neg_lo, neg_lo_nxt;
  logic               neg_hi, neg_hi_nxt, div_zero, div_zero_nxt;
  logic               out_valid_nxt, v_nxt, dz_nxt;
  logic [WIDTH-1:0]   z_nxt, zhi_nxt;

  // Shared adder: subtract for SUB and for every compare
  logic [1:0]       grp;
  logic             alu_sub, carry, ovf_s, lt, a_zero, b_zero, cmp;
  logic [WIDTH-1:0] b_x, res, shift_res, alu_res;
  logic [WIDTH:0]   sum;
  logic             alu_v;
  shift_op_t        sh_op;

  assign grp     = ALUFun[5:4];
  assign alu_sub = (grp == GRP_CMP) || ((grp == GRP_ARITH) && ALUFun[0]);
  assign b_x     = alu_sub ? ~B : B;
  assign sum     = {1'b0, A} + {1'b0, b_x} + {{WIDTH{1'b0}}, alu_sub};
  assign res     = sum[MSB:0];
  assign carry   = sum[WIDTH];
  assign ovf_s   = (A[MSB] == b_x[MSB]) && (res[MSB] != A[MSB]);
  assign lt      = Sign ? (res[MSB] ^ ovf_s) : !carry;
  assign a_zero  = (A == '0);
  assign b_zero  = (B == '0);
  assign sh_op   = ALUFun[1] ? SH_SRA : (ALUFun[0] ? SH_SRL : SH_SLL);

  alu_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .data     (B),
    .shamt    (A[SHW-1:0]),
    .op       (sh_op),
    .result_c (shift_res)
  );

  always_comb begin
    alu_res = A;
    alu_v   = 1'b0;
    cmp     = 1'b0;
    case (grp)
      GRP_ARITH: begin
        alu_res = res;
        alu_v   = Sign ? ovf_s : (carry ^ alu_sub);
      end
      GRP_LOGIC: begin
        case (ALUFun)
          FUN_AND: alu_res = A & B;
          FUN_OR:  alu_res = A | B;
          FUN_XOR: alu_res = A ^ B;
          FUN_NOR: alu_res = ~(A | B);
          default: alu_res = A;
        endcase
      end
      GRP_SHIFT: alu_res = shift_res;
      default: begin
        case (ALUFun)
          FUN_EQ:  cmp = (res == '0);
          FUN_NE:  cmp = (res != '0);
          FUN_LT:  cmp = lt;
          FUN_LEZ: cmp = Sign ? (A[MSB] || a_zero) : a_zero;
          FUN_LTZ: cmp = Sign && A[MSB];
          FUN_GTZ: cmp = Sign ? (!A[MSB] && !a_zero) : !a_zero;
          default: cmp = 1'b0;
        endcase
        alu_res = WIDTH'(cmp);
      end
    endcase
  end

  // Iterative datapath: magnitudes in, sign applied in FIX
  logic             accept, md_mul, md_div;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_sh, div_trial;
  logic [2*WIDTH-1:0] product, prod_fix;

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign md_mul    = (MD == MD_MUL);
  assign md_div    = (MD == MD_DIV);
  assign mag_a     = (Sign && A[MSB]) ? -A : A;
  assign mag_b     = (Sign && B[MSB]) ? -B : B;
  assign mul_sum   = hi + {1'b0, (lo[0] ? opnd : '0)};
  assign div_sh    = {hi[MSB:0], lo[MSB]};
  assign div_trial = div_sh - {1'b0, opnd};
  assign product   = {hi[MSB:0], lo};
  assign prod_fix  = neg_lo ? -product : product;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hi_nxt        = hi;
    lo_nxt        = lo;
    opnd_nxt      = opnd;
    is_div_nxt    = is_div;
    neg_lo_nxt    = neg_lo;
    neg_hi_nxt    = neg_hi;
    div_zero_nxt  = div_zero;
    out_valid_nxt = out_valid && !out_ready;
    z_nxt         = Z;
    zhi_nxt       = Zhi;
    v_nxt         = V;
    dz_nxt        = dz;
    case (state)
      IDLE: begin
        if (accept) begin
          if (md_mul || md_div) begin
            state_nxt    = md_mul ? MUL : DIV;
            cnt_nxt      = SHW'(WIDTH - 1);
            hi_nxt       = '0;
            lo_nxt       = md_mul ? mag_b : mag_a;
            // On divide-by-zero the divisor slot carries raw A for Zhi
            opnd_nxt     = md_mul ? mag_a : (b_zero ? A : mag_b);
            is_div_nxt   = md_div;
            neg_lo_nxt   = Sign && (A[MSB] ^ B[MSB]);
            neg_hi_nxt   = Sign && A[MSB];
            div_zero_nxt = md_div && b_zero;
          end else begin
            out_valid_nxt = 1'b1;
            z_nxt         = alu_res;
            zhi_nxt       = '0;
            v_nxt         = alu_v;
            dz_nxt        = 1'b0;
          end
        end
      end
      MUL: begin
        hi_nxt  = {1'b0, mul_sum[WIDTH:1]};
        lo_nxt  = {mul_sum[0], lo[MSB:1]};
        cnt_nxt = cnt - SHW'(1);
        if (cnt == '0) state_nxt = FIX;
      end
      DIV: begin
        hi_nxt  = div_trial[WIDTH] ? div_sh : div_trial;
        lo_nxt  = {lo[WIDTH-2:0], !div_trial[WIDTH]};
        cnt_nxt = cnt - SHW'(1);
        if (cnt == '0) state_nxt = FIX;
      end
      FIX: begin
        state_nxt     = IDLE;
        out_valid_nxt = 1'b1;
        v_nxt         = 1'b0;
        dz_nxt        = div_zero;
        if (!is_div) begin
          {zhi_nxt, z_nxt} = prod_fix;
        end else if (div_zero) begin
          z_nxt   = '1;
          zhi_nxt = opnd;
        end else begin
          z_nxt   = neg_lo ? -lo : lo;
          zhi_nxt = neg_hi ? -hi[MSB:0] : hi[MSB:0];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      opnd      <= '0;
      is_div    <= 1'b0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      div_zero  <= 1'b0;
      out_valid <= 1'b0;
      Z         <= '0;
      Zhi       <= '0;
      V         <= 1'b0;
      dz        <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hi        <= hi_nxt;
      lo        <= lo_nxt;
      opnd      <= opnd_nxt;
      is_div    <= is_div_nxt;
      neg_lo    <= neg_lo_nxt;
      neg_hi    <= neg_hi_nxt;
      div_zero  <= div_zero_nxt;
      out_valid <= out_valid_nxt;
      Z         <= z_nxt;
      Zhi       <= zhi_nxt;
      V         <= v_nxt;
      dz        <= dz_nxt;
    end
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (power of two, >= 8).
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation presented on A/B/ALUFun/Sign/MD.
REQ-006 in_ready  output  1  block accepts an operation this cycle.
REQ-007 A  input  WIDTH  operand A; also the shift amount, taken from A[SHW-1:0].
REQ-008 B  input  WIDTH  operand B; also the shift source.
REQ-009 ALUFun  input  6  single-cycle op code, used when MD=00.
REQ-010 Sign  input  1  1 = signed arithmetic, compare, multiply and divide.
REQ-011 MD  input  2  00 ALU op, 01 MUL, 10 DIV, 11 reserved (treated as 00).
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer takes the result.
REQ-014 Z  output  WIDTH  ALU result, low product, or quotient.
REQ-015 Zhi  output  WIDTH  high product or remainder; 0 for ALU ops.
REQ-016 V  output  1  signed or unsigned add/sub overflow; 0 for other ops.
REQ-017 dz  output  1  divide-by-zero flag; 0 for other ops.

Function
REQ-018 Accept condition: in_valid && in_ready, where in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-019 ALU ops have 1-cycle latency: accepted at cycle t -> out_valid=1 at t+1.
REQ-020 ALUFun[5:4] selects the group: 00 arith, 01 logic, 10 shift, 11 compare.
REQ-021 Arith group: 000000 ADD, 000001 SUB (A-B); V = signed overflow if Sign=1, else carry/borrow-out.
REQ-022 Logic group: 011000 AND, 011110 OR, 010110 XOR, 010001 NOR; any other logic code -> Z=A.
REQ-023 Shift group (B shifted by A[SHW-1:0]): 100000 SLL, 100001 SRL, 10xx1x SRA filling with B[WIDTH-1].
REQ-024 Compare group returns a zero-extended 1-bit result.
 - 110011 EQ, 110001 NE, 110101 LT (A-B; signed if Sign=1, else unsigned).
 - 111101 LEZ, 111011 LTZ, 111111 GTZ; Sign=0 treats A as unsigned.
REQ-025 MUL: WIDTH-cycle radix-2 shift-add on operand magnitudes, then one FIX cycle applying the sign; {Zhi,Z} = full 2*WIDTH product.
REQ-026 DIV: WIDTH-cycle restoring divide on magnitudes, then FIX; Z = quotient truncated toward zero, Zhi = remainder with the sign of A.
REQ-027 MUL/DIV latency: accepted at t -> out_valid at t+WIDTH+2; in_ready=0 throughout.
REQ-028 Divide by zero: Z = all ones, Zhi = A, dz=1, same latency.
REQ-029 Signed MIN / -1: Z = MIN, Zhi = 0, dz=0.
REQ-030 States: IDLE -> MUL or DIV (counter loaded with WIDTH-1) -> FIX when counter==0 -> IDLE with out_valid set.
REQ-031 Backpressure: while out_valid && !out_ready, Z/Zhi/V/dz are held stable and no new op is accepted.
REQ-032 out_valid clears on out_ready unless a new ALU op is accepted in the same cycle, in which case the new result appears the next cycle.

Reset
REQ-033 reset=1 forces state=IDLE, counter=0, out_valid=0, Z=0, Zhi=0, V=0, dz=0 on the next edge, including mid-MUL/DIV; the aborted op produces no result.
REQ-034 The cycle after reset deasserts, in_ready=1.

Structure
REQ-035 Package alu_pkg holds the ALUFun and MD encodings, the state enum (IDLE, MUL, DIV, FIX) and the group-select constants.
REQ-036 Sub-module alu_shifter: WIDTH-parametrised log-stage barrel shifter (SLL/SRL/SRA), purely combinational.
REQ-037 Add/sub and compare logic share one WIDTH+1-bit adder.

Verification (WIDTH=32)
REQ-038 ADD with A=0x7FFFFFFF, B=1, Sign=1 -> next cycle Z=0x80000000, V=1, Zhi=0.
REQ-039 SRA with A=4, B=0xF0000000 -> Z=0xFF000000; SRL with the same operands -> Z=0x0F000000.
REQ-040 MUL with Sign=1, A=-3, B=5 -> out_valid at t+34 with Z=0xFFFFFFF1, Zhi=0xFFFFFFFF; in_ready=0 for cycles t+1..t+34.
REQ-041 DIV with Sign=1, A=-7, B=2 -> Z=0xFFFFFFFD, Zhi=0xFFFFFFFF; DIV with A=5, B=0 -> Z=0xFFFFFFFF, Zhi=5, dz=1.
REQ-042 out_ready held low for 3 cycles after a result -> outputs stable, in_ready=0, in_valid ignored; one cycle after out_ready=1, out_valid=0.
REQ-043 reset asserted 10 cycles into a DIV -> next cycle out_valid=0, then in_ready=1, and no stale result ever appears.
